// File: rtl/llc_output_encoder_pkg.sv
// Shared types and constants for the LLC egress encoder.
// Used by llc_out_fifo and llc_output_encoder (optional LLC_OUT_STATS_EN counters).
package llc_output_encoder_pkg;

    localparam int LLC_OUT_FIFO_DEPTH = 2;
    localparam int LLC_RSP_OUT_W      = 64;
    localparam int LLC_FWD_OUT_W      = 64;
    localparam int LLC_MEM_REQ_W      = 192;
    localparam int LLC_DMA_RSP_OUT_W  = 192;

    typedef logic [LLC_RSP_OUT_W-1:0]     llc_rsp_out_t;
    typedef logic [LLC_FWD_OUT_W-1:0]     llc_fwd_out_t;
    typedef logic [LLC_MEM_REQ_W-1:0]     llc_mem_req_t;
    typedef logic [LLC_DMA_RSP_OUT_W-1:0] llc_dma_rsp_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } llc_out_drain_t;

    // Add a small increment to a 16-bit counter, clamping at all-ones.
    function automatic logic [15:0] llc_sat_add16(input logic [15:0] v, input logic [2:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {14'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/llc_out_fifo.sv
// Per-channel egress FIFO: registered full/empty flags, head driven from storage registers.
// No push->valid or pop->space bypass; a push into a full FIFO is dropped and flagged.
module llc_out_fifo
    import llc_output_encoder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = LLC_OUT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             space_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok_s;
    logic             pop_s;

    assign push_ok_s = push_i & ~full_q;
    assign pop_s     = ready_i & ~empty_q;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CW'(1'b0));
        full_d  = (count_d == CW'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign space_o = ~full_q;
    assign valid_o = ~empty_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign drop_o  = push_i & full_q;

endmodule

// File: rtl/llc_output_encoder.sv
// LLC egress encoder: four independent channel FIFOs, drain FSM, idle and sticky overflow flags.
// Define LLC_OUT_STATS_EN to add per-channel handshake counters and a saturating drop counter.
module llc_output_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int DEPTH = LLC_OUT_FIFO_DEPTH,
    parameter int RSP_W = LLC_RSP_OUT_W,
    parameter int FWD_W = LLC_FWD_OUT_W,
    parameter int MEM_W = LLC_MEM_REQ_W,
    parameter int DMA_W = LLC_DMA_RSP_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsp_push,
    input  logic [RSP_W-1:0] rsp_data_in,
    output logic             rsp_space,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSP_W-1:0] rsp_data,
    input  logic             fwd_push,
    input  logic [FWD_W-1:0] fwd_data_in,
    output logic             fwd_space,
    output logic             fwd_valid,
    input  logic             fwd_ready,
    output logic [FWD_W-1:0] fwd_data,
    input  logic             mem_push,
    input  logic [MEM_W-1:0] mem_data_in,
    output logic             mem_space,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [MEM_W-1:0] mem_data,
    input  logic             dma_push,
    input  logic [DMA_W-1:0] dma_data_in,
    output logic             dma_space,
    output logic             dma_valid,
    input  logic             dma_ready,
    output logic [DMA_W-1:0] dma_data,
    input  logic             drain_req,
    output logic             drain_busy,
    output logic             drain_done,
    output logic             idle,
    output logic             overflow_err
`ifdef LLC_OUT_STATS_EN
    ,
    output logic [31:0]      rsp_sent_cnt,
    output logic [31:0]      fwd_sent_cnt,
    output logic [31:0]      mem_sent_cnt,
    output logic [31:0]      dma_sent_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    logic [3:0]     empty_s;
    logic [3:0]     drop_s;
    logic [3:0]     push_s;
    logic           all_empty_s;
    logic           idle_q;
    logic           overflow_q;
    llc_out_drain_t state_q, state_d;

    llc_out_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk(clk), .rst_n(rst), .push_i(rsp_push), .data_i(rsp_data_in),
        .space_o(rsp_space), .valid_o(rsp_valid), .ready_i(rsp_ready),
        .data_o(rsp_data), .empty_o(empty_s[0]), .drop_o(drop_s[0])
    );

    llc_out_fifo #(.WIDTH(FWD_W), .DEPTH(DEPTH)) u_fwd_fifo (
        .clk(clk), .rst_n(rst), .push_i(fwd_push), .data_i(fwd_data_in),
        .space_o(fwd_space), .valid_o(fwd_valid), .ready_i(fwd_ready),
        .data_o(fwd_data), .empty_o(empty_s[1]), .drop_o(drop_s[1])
    );

    llc_out_fifo #(.WIDTH(MEM_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk(clk), .rst_n(rst), .push_i(mem_push), .data_i(mem_data_in),
        .space_o(mem_space), .valid_o(mem_valid), .ready_i(mem_ready),
        .data_o(mem_data), .empty_o(empty_s[2]), .drop_o(drop_s[2])
    );

    llc_out_fifo #(.WIDTH(DMA_W), .DEPTH(DEPTH)) u_dma_fifo (
        .clk(clk), .rst_n(rst), .push_i(dma_push), .data_i(dma_data_in),
        .space_o(dma_space), .valid_o(dma_valid), .ready_i(dma_ready),
        .data_o(dma_data), .empty_o(empty_s[3]), .drop_o(drop_s[3])
    );

    assign push_s      = {dma_push, mem_push, fwd_push, rsp_push};
    assign all_empty_s = &empty_s;

    // Drain state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain next-state; a push in the same cycle keeps DRAIN open since its entry lands next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (all_empty_s && (push_s == 4'b0000)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Quiescence and sticky overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            idle_q     <= all_empty_s;
            overflow_q <= overflow_q | (|drop_s);
        end
    end

    assign drain_busy   = (state_q != IDLE);
    assign drain_done   = (state_q == DONE);
    assign idle         = idle_q;
    assign overflow_err = overflow_q;

`ifdef LLC_OUT_STATS_EN
    logic [3:0]  hs_s;
    logic [2:0]  ndrop_s;
    logic [31:0] sent_q [4];
    logic [15:0] drop_cnt_q;

    assign hs_s    = {dma_valid & dma_ready, mem_valid & mem_ready,
                      fwd_valid & fwd_ready, rsp_valid & rsp_ready};
    assign ndrop_s = {2'b00, drop_s[0]} + {2'b00, drop_s[1]}
                   + {2'b00, drop_s[2]} + {2'b00, drop_s[3]};

    // Handshake counters wrap; the drop counter saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                sent_q[i] <= 32'd0;
            end
            drop_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hs_s[i]) begin
                    sent_q[i] <= sent_q[i] + 32'd1;
                end
            end
            drop_cnt_q <= llc_sat_add16(drop_cnt_q, ndrop_s);
        end
    end

    assign rsp_sent_cnt = sent_q[0];
    assign fwd_sent_cnt = sent_q[1];
    assign mem_sent_cnt = sent_q[2];
    assign dma_sent_cnt = sent_q[3];
    assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_llc_output_encoder.sv
// Self-checking bench for llc_output_encoder: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_llc_output_encoder;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   push_v;
    logic [3:0]   ready_v;
    logic         drain_req;
    logic [191:0] din_v [4];

    logic         rsp_space, rsp_valid, fwd_space, fwd_valid;
    logic         mem_space, mem_valid, dma_space, dma_valid;
    logic [63:0]  rsp_data, fwd_data;
    logic [191:0] mem_data, dma_data;
    logic         drain_busy, drain_done, idle, overflow_err;
`ifdef LLC_OUT_STATS_EN
    logic [31:0]  rsp_sent_cnt, fwd_sent_cnt, mem_sent_cnt, dma_sent_cnt;
    logic [15:0]  drop_cnt;
    logic [31:0]  sent_s [4];
    assign sent_s[0] = rsp_sent_cnt;
    assign sent_s[1] = fwd_sent_cnt;
    assign sent_s[2] = mem_sent_cnt;
    assign sent_s[3] = dma_sent_cnt;
`endif

    always #5 clk = ~clk;

    llc_output_encoder dut (
        .clk(clk), .rst(rst),
        .rsp_push(push_v[0]), .rsp_data_in(din_v[0][63:0]), .rsp_space(rsp_space),
        .rsp_valid(rsp_valid), .rsp_ready(ready_v[0]), .rsp_data(rsp_data),
        .fwd_push(push_v[1]), .fwd_data_in(din_v[1][63:0]), .fwd_space(fwd_space),
        .fwd_valid(fwd_valid), .fwd_ready(ready_v[1]), .fwd_data(fwd_data),
        .mem_push(push_v[2]), .mem_data_in(din_v[2]), .mem_space(mem_space),
        .mem_valid(mem_valid), .mem_ready(ready_v[2]), .mem_data(mem_data),
        .dma_push(push_v[3]), .dma_data_in(din_v[3]), .dma_space(dma_space),
        .dma_valid(dma_valid), .dma_ready(ready_v[3]), .dma_data(dma_data),
        .drain_req(drain_req), .drain_busy(drain_busy), .drain_done(drain_done),
        .idle(idle), .overflow_err(overflow_err)
`ifdef LLC_OUT_STATS_EN
        , .rsp_sent_cnt(rsp_sent_cnt), .fwd_sent_cnt(fwd_sent_cnt),
        .mem_sent_cnt(mem_sent_cnt), .dma_sent_cnt(dma_sent_cnt), .drop_cnt(drop_cnt)
`endif
    );

    logic [3:0]   valid_s, space_s;
    logic [191:0] dout_s [4];
    assign valid_s   = {dma_valid, mem_valid, fwd_valid, rsp_valid};
    assign space_s   = {dma_space, mem_space, fwd_space, rsp_space};
    assign dout_s[0] = {128'd0, rsp_data};
    assign dout_s[1] = {128'd0, fwd_data};
    assign dout_s[2] = mem_data;
    assign dout_s[3] = dma_data;

    // Reference model state
    logic [191:0] mq [4][$];
    bit           ovf_m, idle_m;
    int           phase_m;      // 0 not draining, 1 waiting for empty, 2 completion cycle
    logic [31:0]  sent_m [4];
    int           drop_m;
    int           checks, errors;

    function automatic logic [191:0] wmask(input int c);
        logic [191:0] m;
        m = '1;
        if (c < 2) m = m >> 128;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            sent_m[c] = 32'd0;
        end
        ovf_m   = 1'b0;
        idle_m  = 1'b1;
        phase_m = 0;
        drop_m  = 0;
    endtask

    task automatic model_edge();
        bit all_empty;
        int nd;
        if (!rst) begin
            model_reset();
            return;
        end
        all_empty = 1'b1;
        for (int c = 0; c < 4; c++) if (mq[c].size() != 0) all_empty = 1'b0;
        case (phase_m)
            0:       if (drain_req) phase_m = 1;
            1:       if (all_empty && push_v == 4'b0000) phase_m = 2;
            default: phase_m = 0;
        endcase
        idle_m = all_empty;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            int sz;
            sz = mq[c].size();
            if (push_v[c] && sz == DEPTH) begin
                ovf_m = 1'b1;
                nd++;
            end
            if (sz > 0 && ready_v[c]) begin
                void'(mq[c].pop_front());
                sent_m[c] = sent_m[c] + 32'd1;
            end
            if (push_v[c] && sz < DEPTH) mq[c].push_back(din_v[c] & wmask(c));
        end
        drop_m = (drop_m + nd > 65535) ? 65535 : drop_m + nd;
    endtask

    task automatic check_all();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("valid%0d", c), valid_s[c], mq[c].size() != 0);
            chk($sformatf("space%0d", c), space_s[c], mq[c].size() < DEPTH);
            if (mq[c].size() != 0) chk($sformatf("data%0d", c), dout_s[c], mq[c][0]);
        end
        chk("idle", idle, idle_m);
        chk("drain_busy", drain_busy, phase_m != 0);
        chk("drain_done", drain_done, phase_m == 2);
        chk("overflow_err", overflow_err, ovf_m);
`ifdef LLC_OUT_STATS_EN
        for (int c = 0; c < 4; c++) chk($sformatf("sent_cnt%0d", c), sent_s[c], sent_m[c]);
        chk("drop_cnt", drop_cnt, drop_m);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        push_v    = 4'b0000;
        ready_v   = 4'b0000;
        drain_req = 1'b0;
        for (int c = 0; c < 4; c++) din_v[c] = 192'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        clear_inputs();
        model_reset();

        // Reset state
        @(negedge clk);
        check_all();
        for (int c = 0; c < 4; c++) chk($sformatf("rst_data%0d", c), dout_s[c], 192'd0);
        cycle();
        rst = 1'b1;
        cycle();

        // 1: single rsp message, latency one cycle, idle follows
        push_v[0] = 1'b1; din_v[0] = 192'h1234; ready_v[0] = 1'b1;
        cycle();
        chk("t1_valid", rsp_valid, 1'b1);
        chk("t1_data", rsp_data, 64'h1234);
        push_v[0] = 1'b0;
        cycle();
        chk("t1_popped", rsp_valid, 1'b0);
        chk("t1_idle0", idle, 1'b0);
        cycle();
        chk("t1_idle1", idle, 1'b1);
        ready_v[0] = 1'b0;

        // 2: overflow on mem, in-order delivery, space returns after first pop
        push_v[2] = 1'b1; din_v[2] = 192'hA;
        cycle();
        din_v[2] = 192'hB;
        cycle();
        chk("t2_full", mem_space, 1'b0);
        din_v[2] = 192'hC;
        cycle();
        chk("t2_ovf", overflow_err, 1'b1);
        chk("t2_headA", mem_data, 192'hA);
        push_v[2] = 1'b0; ready_v[2] = 1'b1;
        cycle();
        chk("t2_headB", mem_data, 192'hB);
        chk("t2_space", mem_space, 1'b1);
        cycle();
        chk("t2_empty", mem_valid, 1'b0);
        ready_v[2] = 1'b0;

        // 3: simultaneous push and pop with one entry held
        push_v[1] = 1'b1; din_v[1] = 192'h11;
        cycle();
        din_v[1] = 192'hAA; ready_v[1] = 1'b1;
        cycle();
        chk("t3_head", fwd_data, 64'hAA);
        push_v[1] = 1'b0;
        cycle();
        chk("t3_occ1", fwd_valid, 1'b0);
        ready_v[1] = 1'b0;

        // 4: drain with two queued dma entries
        push_v[3] = 1'b1; din_v[3] = 192'h1;
        cycle();
        din_v[3] = 192'h2;
        cycle();
        push_v[3] = 1'b0; drain_req = 1'b1;
        cycle();
        drain_req = 1'b0;
        chk("t4_busy", drain_busy, 1'b1);
        cycle();
        chk("t4_nodone", drain_done, 1'b0);
        ready_v[3] = 1'b1;
        cycle();
        cycle();
        chk("t4_empty", dma_valid, 1'b0);
        chk("t4_nodone2", drain_done, 1'b0);
        ready_v[3] = 1'b0;
        cycle();
        chk("t4_done", drain_done, 1'b1);
        cycle();
        chk("t4_unbusy", drain_busy, 1'b0);

        // 5: drain when empty, repeated request while busy ignored
        drain_req = 1'b1;
        cycle();
        chk("t5_busy", drain_busy, 1'b1);
        cycle();
        chk("t5_done", drain_done, 1'b1);
        drain_req = 1'b0;
        cycle();
        chk("t5_single", drain_done, 1'b0);
        cycle();
        chk("t5_idle", drain_busy, 1'b0);

        // 6: reset in the middle of a drain with entries queued
        push_v = 4'b0101; din_v[0] = 192'h55; din_v[2] = 192'h66;
        cycle();
        push_v = 4'b0000; drain_req = 1'b1;
        cycle();
        drain_req = 1'b0;
        cycle();
        chk("t6_busy", drain_busy, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_valid", valid_s, 4'b0000);
        chk("t6_idle", idle, 1'b1);
        chk("t6_done", drain_done, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
`ifdef LLC_OUT_STATS_EN
        chk("t6_cnt0", rsp_sent_cnt, 32'd0);
        push_v[0] = 1'b1; ready_v[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din_v[0] = {160'd0, $urandom};
            cycle();
        end
        push_v[0] = 1'b0;
        cycle();
        chk("t6_cnt32", rsp_sent_cnt, 32'd32);
        clear_inputs();
`endif

        // Random traffic with an occasional drain and one mid-run reset
        for (int i = 0; i < 500; i++) begin
            push_v    = 4'($urandom);
            ready_v   = 4'($urandom) | 4'($urandom);
            drain_req = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 4; c++)
                din_v[c] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 250) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_all();
                cycle();
                rst = 1'b1;
            end
            cycle();
        end

        clear_inputs();
        ready_v = 4'b1111;
        cycle();
        cycle();
        cycle();
        chk("final_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
